multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/multicycle_out_decode.sv | 87 ++++++++
 rtl/multicycle_sequencer.sv | 104 ++++++++++
 tb/tb_multicycle_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, state encoding, control codes and decode helper
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_JAL      = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [2:0] ALU_SUB   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_FUNCT = 3'b111;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       shamt_sel;
    logic       link;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  // S_FETCH doubles as the "unrecognised opcode" answer
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:                return fn == FN_JR ? S_JR : S_EXEC_R;
      OP_LW, OP_SW:            return S_MEM_ADDR;
      OP_ADDI, OP_ORI, OP_LUI: return S_EXEC_I;
      OP_BEQ, OP_BNE:          return S_BRANCH;
      OP_J:                    return S_JUMP;
      OP_JAL:                  return S_JAL;
      default:                 return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_out_decode.sv
// multicycle_out_decode: combinational control-output decode of the sequencer state
// Ports: state (current state), opcode/funct (instruction fields), zero (ALU flag),
//        variant (per-instruction flag: SW/BNE from DECODE, reg_dst for ALU_WB),
//        rdy (memory ready, constant 1 without MEM_HANDSHAKE_EN), ctrl (all control outputs)
import mips_pkg::*;
module multicycle_out_decode (
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       variant,
  input  logic       rdy,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = decode_next(opcode, funct) == S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.shamt_sel = funct == FN_SLL || funct == FN_SRL;
        ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = opcode == OP_ORI ? ALU_OR : opcode == OP_LUI ? ALU_LUI : ALU_ADD;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = variant;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        ctrl.pc_write  = zero ^ variant;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_RS;
      end
      S_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle MIPS control FSM (state register + next-state logic)
// Ports: clk, reset (async active-high), opcode/funct (IR fields), zero (ALU flag),
//        mem_ready (only with MEM_HANDSHAKE_EN: memory access completes this cycle),
//        1-bit controls, alu_src_b[1:0], alu_op[2:0], pc_source[1:0], state[3:0] (debug)
// Option: MEM_HANDSHAKE_EN makes FETCH, MEM_RD and MEM_WR wait for mem_ready.
import mips_pkg::*;
module multicycle_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef MEM_HANDSHAKE_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       shamt_sel,
  output logic       link,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state
);
  state_t state_q, state_d;
  // Variant bit captured while opcode/funct are valid, so later states never look at them:
  // SW vs LW and BNE vs BEQ from DECODE, reg_dst for ALU_WB from EXEC_R/EXEC_I.
  logic  variant_q, variant_d;
  logic  rdy;
  ctrl_t dec;
`ifdef MEM_HANDSHAKE_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  always_comb begin
    state_d   = S_FETCH;
    variant_d = variant_q;
    case (state_q)
      S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d   = decode_next(opcode, funct);
        variant_d = opcode == OP_SW || opcode == OP_BNE;
      end
      S_MEM_ADDR: state_d = variant_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC_R: begin
        state_d   = S_ALU_WB;
        variant_d = 1'b1;
      end
      S_EXEC_I: begin
        state_d   = S_ALU_WB;
        variant_d = 1'b0;
      end
      default:    state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      variant_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      variant_q <= variant_d;
    end
  end
  multicycle_out_decode u_dec (
    .state   (state_q),
    .opcode  (opcode),
    .funct   (funct),
    .zero    (zero),
    .variant (variant_q),
    .rdy     (rdy),
    .ctrl    (dec)
  );
  // Reset silences every control output at once, even mid-instruction.
  ctrl_t c;
  assign c = reset ? '0 : dec;
  assign pc_write   = c.pc_write;
  assign ir_write   = c.ir_write;
  assign iord       = c.iord;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign reg_write  = c.reg_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign alu_src_a  = c.alu_src_a;
  assign shamt_sel  = c.shamt_sel;
  assign link       = c.link;
  assign illegal_op = c.illegal_op;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = c.alu_op;
  assign pc_source  = c.pc_source;
  assign state      = state_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic zero;
`ifdef MEM_HANDSHAKE_EN
  logic mem_ready;
`endif
  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, shamt_sel, link, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef MEM_HANDSHAKE_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .shamt_sel(shamt_sel), .link(link), .illegal_op(illegal_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .state(state)
  );
  // {state, pc_write ir_write iord mem_read mem_write reg_write reg_dst mem_to_reg
  //  alu_src_a shamt_sel link illegal_op, alu_src_b, alu_op, pc_source}
  logic [22:0] obs;
  assign obs = {state, pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, shamt_sel, link, illegal_op, alu_src_b, alu_op, pc_source};
  localparam logic [22:0] E_ZERO   = 23'd0;
  localparam logic [22:0] E_FETCH  = {4'd0,  12'b1101_0000_0000, 2'b01, 3'b100, 2'b00};
  localparam logic [22:0] E_DEC    = {4'd1,  12'b0000_0000_0000, 2'b11, 3'b100, 2'b00};
  localparam logic [22:0] E_DECILL = {4'd1,  12'b0000_0000_0001, 2'b11, 3'b100, 2'b00};
  localparam logic [22:0] E_MADDR  = {4'd2,  12'b0000_0000_1000, 2'b10, 3'b100, 2'b00};
  localparam logic [22:0] E_MRD    = {4'd3,  12'b0011_0000_0000, 2'b00, 3'b000, 2'b00};
  localparam logic [22:0] E_MWB    = {4'd4,  12'b0000_0101_0000, 2'b00, 3'b000, 2'b00};
  localparam logic [22:0] E_MWR    = {4'd5,  12'b0010_1000_0000, 2'b00, 3'b000, 2'b00};
  localparam logic [22:0] E_EXR    = {4'd6,  12'b0000_0010_1000, 2'b00, 3'b111, 2'b00};
  localparam logic [22:0] E_EXRSH  = {4'd6,  12'b0000_0010_1100, 2'b00, 3'b111, 2'b00};
  localparam logic [22:0] E_ADDI   = {4'd7,  12'b0000_0000_1000, 2'b10, 3'b100, 2'b00};
  localparam logic [22:0] E_ORI    = {4'd7,  12'b0000_0000_1000, 2'b10, 3'b101, 2'b00};
  localparam logic [22:0] E_LUI    = {4'd7,  12'b0000_0000_1000, 2'b10, 3'b110, 2'b00};
  localparam logic [22:0] E_WBR    = {4'd8,  12'b0000_0110_0000, 2'b00, 3'b000, 2'b00};
  localparam logic [22:0] E_WBI    = {4'd8,  12'b0000_0100_0000, 2'b00, 3'b000, 2'b00};
  localparam logic [22:0] E_BRT    = {4'd9,  12'b1000_0000_1000, 2'b00, 3'b000, 2'b01};
  localparam logic [22:0] E_BRN    = {4'd9,  12'b0000_0000_1000, 2'b00, 3'b000, 2'b01};
  localparam logic [22:0] E_JUMP   = {4'd10, 12'b1000_0000_0000, 2'b00, 3'b000, 2'b10};
  localparam logic [22:0] E_JR     = {4'd11, 12'b1000_0000_0000, 2'b00, 3'b000, 2'b11};
  localparam logic [22:0] E_JAL    = {4'd12, 12'b1000_0100_0010, 2'b00, 3'b000, 2'b10};
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [22:0] ex);
    tests++;
    assert (obs === ex) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask
  initial begin
    reset = 1'b1;
    instr(6'h08, 6'h00, 1'b0);
`ifdef MEM_HANDSHAKE_EN
    mem_ready = 1'b1;
`endif
    repeat (2) tick;
    chk("reset_outputs", E_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("addi_c1", E_FETCH);
    tick; chk("addi_c2", E_DEC);
    tick; chk("addi_c3", E_ADDI);
    tick; chk("addi_c4", E_WBI);
    tick; instr(6'h23, 6'h00, 1'b0); chk("lw_c1", E_FETCH);
    tick; chk("lw_c2", E_DEC);
    tick; chk("lw_c3", E_MADDR);
    tick;
`ifdef MEM_HANDSHAKE_EN
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait", E_MRD);
      tick;
    end
    mem_ready = 1'b1;
    #1;
`endif
    chk("lw_c4", E_MRD);
    tick; chk("lw_c5", E_MWB);
    tick; instr(6'h2b, 6'h00, 1'b0); chk("sw_c1", E_FETCH);
    tick; chk("sw_c2", E_DEC);
    tick; chk("sw_c3", E_MADDR);
    tick; chk("sw_c4", E_MWR);
    tick; instr(6'h00, 6'h20, 1'b0); chk("add_c1", E_FETCH);
    tick; chk("add_c2", E_DEC);
    tick; chk("add_c3", E_EXR);
    tick; chk("add_c4", E_WBR);
    tick; instr(6'h00, 6'h00, 1'b0); chk("sll_c1", E_FETCH);
    tick; chk("sll_c2", E_DEC);
    tick; chk("sll_c3", E_EXRSH);
    tick; chk("sll_c4", E_WBR);
    tick; instr(6'h0d, 6'h00, 1'b0); chk("ori_c1", E_FETCH);
    tick; chk("ori_c2", E_DEC);
    tick; chk("ori_c3", E_ORI);
    tick; chk("ori_c4", E_WBI);
    tick; instr(6'h0f, 6'h00, 1'b0); chk("lui_c1", E_FETCH);
    tick; chk("lui_c2", E_DEC);
    tick; chk("lui_c3", E_LUI);
    tick; chk("lui_c4", E_WBI);
    tick; instr(6'h04, 6'h00, 1'b1); chk("beq_t_c1", E_FETCH);
    tick; chk("beq_t_c2", E_DEC);
    tick; chk("beq_t_c3", E_BRT);
    tick; instr(6'h04, 6'h00, 1'b0); chk("beq_n_c1", E_FETCH);
    tick; chk("beq_n_c2", E_DEC);
    tick; chk("beq_n_c3", E_BRN);
    tick; instr(6'h05, 6'h00, 1'b0); chk("bne_t_c1", E_FETCH);
    tick; chk("bne_t_c2", E_DEC);
    tick; opcode = 6'h3f; #1; chk("bne_t_c3", E_BRT);
    tick; instr(6'h05, 6'h00, 1'b1); chk("bne_n_c1", E_FETCH);
    tick; chk("bne_n_c2", E_DEC);
    tick; chk("bne_n_c3", E_BRN);
    tick; instr(6'h02, 6'h00, 1'b0); chk("j_c1", E_FETCH);
    tick; chk("j_c2", E_DEC);
    tick; chk("j_c3", E_JUMP);
    tick; instr(6'h00, 6'h08, 1'b0); chk("jr_c1", E_FETCH);
    tick; chk("jr_c2", E_DEC);
    tick; chk("jr_c3", E_JR);
    tick; instr(6'h03, 6'h00, 1'b0); chk("jal_c1", E_FETCH);
    tick; chk("jal_c2", E_DEC);
    tick; chk("jal_c3", E_JAL);
    tick; instr(6'h3f, 6'h00, 1'b0); chk("ill_c1", E_FETCH);
    tick; chk("ill_c2", E_DECILL);
    tick; instr(6'h23, 6'h00, 1'b0); chk("ill_c3", E_FETCH);
    tick; chk("rst_lw_c2", E_DEC);
    tick; chk("rst_lw_c3", E_MADDR);
    tick; chk("rst_lw_c4", E_MRD);
    reset = 1'b1;
    #1;
    chk("rst_async", E_ZERO);
    tick; chk("rst_held", E_ZERO);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_fetch", E_FETCH);
    tick; chk("rst_release_dec", E_DEC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
